// File: rtl/bash_hash_params_pkg.sv
// Shared constants and types for the bash register map.
// Control word offsets, status bit positions and FSM states.
package bash_hash_params_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACK,
    S_RUN
  } state_t;

  localparam int unsigned OFS_L        = 0;
  localparam int unsigned OFS_CMD      = 1;
  localparam int unsigned OFS_STATUS   = 2;
  localparam int unsigned OFS_IRQ_EN   = 3;
  localparam int unsigned OFS_IRQ_STAT = 4;

  localparam int ST_BUSY   = 0;
  localparam int ST_ACTIVE = 1;
  localparam int ST_RDY    = 2;
  localparam int ST_DONE   = 3;
  localparam int ST_ERR    = 4;
  localparam int ST_W      = 5;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  localparam int CMD_PREP  = 0;
  localparam int CMD_START = 1;

endpackage

// File: rtl/bash_bytemask_reg.sv
// Register with per-byte write enables.
// Bit i is written when enable i/8 is set.
module bash_bytemask_reg #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(WIDTH+7)/8-1:0]   be,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q
);

  // update only the bits belonging to enabled bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (be[i/8]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/bash_regmap_v2.sv
// Register map and start/ack sequencer for the bash core.
// X/L/IRQ_EN are byte-masked; Y and STATUS are read-only.
module bash_regmap_v2 #(
  parameter int XLEN        = 32,
  parameter int ADDRLEN     = 10,
  parameter int X_WORDS     = 32,
  parameter int Y_WORDS     = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [XLEN/8-1:0]        we_i,
  input  logic [ADDRLEN-1:0]       addr_i,
  input  logic [XLEN-1:0]          wrdata_i,
  output logic [XLEN-1:0]          rddata_o,
  input  logic                     active_i,
  input  logic                     rdy_i,
  output logic                     prep_o,
  output logic                     start_o,
  output logic [XLEN-1:0]          l_reg_o,
  output logic [XLEN*X_WORDS-1:0]  x_reg_o,
  input  logic [XLEN*Y_WORDS-1:0]  y_reg_i,
  output logic                     irq_o
);

  import bash_hash_params_pkg::*;

  localparam int BYTES = XLEN / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int WW    = ADDRLEN - OFS;
  localparam int CB    = X_WORDS + Y_WORDS;
  localparam int CW    = $clog2(ACK_TIMEOUT + 1);

  localparam logic [WW-1:0] W_XEND = WW'(X_WORDS);
  localparam logic [WW-1:0] W_L    = WW'(CB + OFS_L);
  localparam logic [WW-1:0] W_CMD  = WW'(CB + OFS_CMD);
  localparam logic [WW-1:0] W_ST   = WW'(CB + OFS_STATUS);
  localparam logic [WW-1:0] W_IEN  = WW'(CB + OFS_IRQ_EN);
  localparam logic [WW-1:0] W_IST  = WW'(CB + OFS_IRQ_STAT);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT);

  logic [WW-1:0] w;
  logic          wr;
  logic          rd;
  logic          busy;
  logic          is_x;
  logic          ien;
  logic          done;
  logic          err;
  logic          cmd_wr;
  logic [1:0]    cmd;
  logic [1:0]    clr;
  logic          prep_n;
  logic          err_set;
  logic          done_set;
  logic [ST_W-1:0] status;
  logic [XLEN-1:0] rd_val;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_inc;
  state_t        state;
  state_t        state_n;

  assign w      = addr_i[ADDRLEN-1:OFS];
  assign wr     = en_i & (|we_i);
  assign rd     = en_i & ~(|we_i);
  assign busy   = (state != S_IDLE);
  assign is_x   = (w < W_XEND);
  assign cmd_wr = wr & (w == W_CMD) & we_i[0];
  assign cmd    = wrdata_i[1:0];
  assign clr    = (wr && w == W_IST && we_i[0]) ? wrdata_i[1:0] : 2'b00;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign irq_o  = ien & (done | err);

  generate
    if (OFS > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^addr_i[OFS-1:0];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < X_WORDS; gi++) begin : g_x
      bash_bytemask_reg #(.WIDTH(XLEN)) u_x (
        .clk (clk_i),
        .rst (rst_i),
        .be  (we_i & {BYTES{wr & ~busy & (w == WW'(gi))}}),
        .d   (wrdata_i),
        .q   (x_reg_o[gi*XLEN +: XLEN])
      );
    end
  endgenerate

  bash_bytemask_reg #(.WIDTH(XLEN)) u_l (
    .clk (clk_i),
    .rst (rst_i),
    .be  (we_i & {BYTES{wr & ~busy & (w == W_L)}}),
    .d   (wrdata_i),
    .q   (l_reg_o)
  );

  bash_bytemask_reg #(.WIDTH(1)) u_ien (
    .clk (clk_i),
    .rst (rst_i),
    .be  (we_i[0] & wr & (w == W_IEN)),
    .d   (wrdata_i[0]),
    .q   (ien)
  );

  // sequencer state and ack-timeout counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state, core pulses and error/done events
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    start_o  = 1'b0;
    prep_n   = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (cmd_wr && (busy || cmd == 2'b11)) err_set = 1'b1;
    if (wr && busy && (is_x || w == W_L)) err_set = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (cmd_wr && cmd == 2'b01) prep_n = 1'b1;
        if (cmd_wr && cmd == 2'b10) state_n = S_START;
      end
      S_START: begin
        start_o = 1'b1;
        cnt_n   = '0;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cnt_n = cnt_inc;
        if (active_i) begin
          state_n = S_RUN;
        end else if (cnt_inc == CNT_MAX) begin
          err_set = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (!active_i) begin
          done_set = 1'b1;
          state_n  = S_IDLE;
        end
      end
    endcase
  end

  // sticky flags: set events win over write-one-to-clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done   <= 1'b0;
      err    <= 1'b0;
      prep_o <= 1'b0;
    end else begin
      done   <= done_set | (done & ~clr[IRQ_DONE]);
      err    <= err_set | (err & ~clr[IRQ_ERR]);
      prep_o <= prep_n;
    end
  end

  // status word from live inputs and sticky flags
  always_comb begin
    status            = '0;
    status[ST_BUSY]   = busy;
    status[ST_ACTIVE] = active_i;
    status[ST_RDY]    = rdy_i;
    status[ST_DONE]   = done;
    status[ST_ERR]    = err;
  end

  // read decode
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < X_WORDS; i++) begin
      if (w == WW'(i)) rd_val = x_reg_o[i*XLEN +: XLEN];
    end
    for (int j = 0; j < Y_WORDS; j++) begin
      if (w == WW'(X_WORDS + j)) rd_val = y_reg_i[j*XLEN +: XLEN];
    end
    unique case (1'b1)
      (w == W_L):   rd_val = l_reg_o;
      (w == W_ST):  rd_val = XLEN'(status);
      (w == W_IEN): rd_val = XLEN'(ien);
      (w == W_IST): rd_val = XLEN'({err, done});
      default: ;
    endcase
  end

  // registered read data, held between reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rddata_o <= '0;
    else if (rd) rddata_o <= rd_val;
  end

endmodule
